famicom_cpu_bus_master: RTL and testbench
=========================================

# famicom_cpu_bus_master

Initiator side of the Famicom CPU cartridge bus. It generates the M2 clock, /ROMSEL, R/W, address and data waveforms that a cartridge responder decodes, and turns simple host requests (read or write one byte) into correctly timed bus cycles. M2 runs continuously, as on a console, so mapper counters and power-on detection logic in the cartridge see a live clock even when the bus is idle. It sits in the cartridge tester/dumper fabric between a host command engine and the physical cartridge connector.

## Interface
- `M2_LOW_CLKS`, 6: clk cycles per M2-low phase; must be ≥ 2.
- `M2_HIGH_CLKS`, 6: clk cycles per M2-high phase; must be ≥ 2.
- `ROMSEL_DELAY_CLKS`, 1: clk cycles from M2 rise to /ROMSEL fall; must be < `M2_HIGH_CLKS`. Any violated constraint is an elaboration error.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: host has a request.
- `req_ready` out 1: request accepted this clk when `req_valid & req_ready`.
- `req_addr` in 16: CPU address; bit 15 selects the ROM space.
- `req_rw` in 1: 1 = read, 0 = write.
- `req_wdata` in 8: write data.
- `rsp_valid` out 1: one-clk pulse on transaction completion.
- `rsp_rdata` out 8: read data, valid with `rsp_valid` on reads.
- `m2` out 1: M2 clock to the cartridge.
- `romsel` out 1: /ROMSEL, active-low.
- `cpu_rw` out 1: R/W to the cartridge.
- `cpu_addr` out 15: A14..A0.
- `cpu_data_out` out 8: data driven toward the cartridge.
- `cpu_data_oe` out 1: data driver enable.
- `cpu_data_in` in 8: data from the cartridge.
- `irq` in 1: cartridge /IRQ, active-low, asynchronous.
- `irq_sync` out 1: `irq` after a 2-flop synchronizer.
- `cycle_count` out 16: number of completed M2 cycles; wraps modulo 2^16.

## Operation
- Two-state FSM: LOW (`m2`=0) and HIGH (`m2`=1), plus a phase counter. LOW lasts `M2_LOW_CLKS` clks, then HIGH lasts `M2_HIGH_CLKS` clks, then back to LOW. The FSM never stalls.
- `req_ready` = 1 only on the first clk of LOW (counter 0). The request is latched there. Otherwise the cycle is idle.
- Active cycle, from the first clk of LOW onward: `cpu_addr` = `req_addr[14:0]`, `cpu_rw` = `req_rw`, internal A15 = `req_addr[15]`.
- Idle cycle: `cpu_rw` = 1, `cpu_addr` keeps its previous value, and internal A15 = 0, so `romsel` stays 1.
- `romsel` = 0 from HIGH clk index `ROMSEL_DELAY_CLKS` through the last HIGH clk, only when A15 = 1. It returns to 1 on the same edge where `m2` falls.
- Writes: `cpu_data_oe` = 1 and `cpu_data_out` = latched wdata for the whole HIGH phase. `cpu_data_oe` = 0 at all other times.
- Reads: `cpu_data_in` is sampled on the last HIGH clk, which is the edge where `m2` falls.
- `rsp_valid` pulses on the first clk of the following LOW phase, for both reads and writes. `rsp_rdata` updates only on reads and holds otherwise.
- `cycle_count` increments on every M2 fall, including idle cycles.
- All bus outputs are registered; no combinational path from host inputs to cartridge pins.
- `irq_sync` is a 2-flop synchronizer with no filtering.

## Timing
- Reset values: `m2`=0, `romsel`=1, `cpu_rw`=1, `cpu_addr`=0, `cpu_data_out`=0, `cpu_data_oe`=0, `rsp_valid`=0, `rsp_rdata`=0, `irq_sync`=1, `cycle_count`=0. State is LOW with counter 0, so `req_ready`=1 on the first clk after release.
- Let T be the accepting clk and L = `M2_LOW_CLKS`, H = `M2_HIGH_CLKS`:
  - `m2` rises at T+L.
  - `romsel` falls at T+L+`ROMSEL_DELAY_CLKS`.
  - Data is sampled at T+L+H−1.
  - `m2` falls, `romsel` rises and `rsp_valid` pulses at T+L+H.
- Back-to-back: the clk carrying `rsp_valid` is also the next `req_ready` clk, giving one transaction per L+H clks.
- A request presented mid-cycle waits. `req_ready` stays 0 until the next LOW counter-0 clk, and the host holds its inputs.
- Reset asserted mid-cycle: all outputs go to reset values immediately and asynchronously. The pending transaction is dropped with no `rsp_valid`.
- `cycle_count` wraps from 0xFFFF to 0x0000 with no flag.

## Test plan
- Reset release, no requests, L=H=6 → `m2` has a 12-clk period at 50% duty. `romsel` stays 1, `cpu_rw` stays 1, and `cycle_count`=10 after 120 clks.
- Read $8123, `cpu_data_in`=0xA5 → `cpu_addr`=0x0123 and `cpu_rw`=1. `romsel` is low for HIGH clks 1–5. `rsp_valid` pulses at T+12 with `rsp_rdata`=0xA5.
- Write 0x3C to $6000 → `romsel` stays 1 throughout. `cpu_rw`=0 for 12 clks, `cpu_data_oe`=1 only while `m2`=1 with `cpu_data_out`=0x3C, and `rsp_valid` pulses while `rsp_rdata` holds.
- Back-to-back reads $8000/$8001 with `req_valid` held → accepts at T and T+12 and gives 2 `rsp_valid` pulses 12 clks apart, with no idle cycle between.
- `reset_n` low at T+8 of a write → `m2`=0, `cpu_data_oe`=0 and `romsel`=1 immediately, with no `rsp_valid`. After release, `req_ready`=1 on the first clk.
- `irq` falls asynchronously → `irq_sync` falls 2–3 clks later. Also preload 0xFFFF cycles, then one more cycle gives `cycle_count`=0x0000.

Source files
------------

// File: rtl/famicom_cpu_bus_master.sv
// famicom_cpu_bus_master: Famicom CPU cartridge bus initiator with a free-running M2 clock.
// Turns single-byte host read/write requests into timed M2, /ROMSEL, R/W, address and data cycles.
module famicom_cpu_bus_master #(
    parameter int M2_LOW_CLKS       = 6,
    parameter int M2_HIGH_CLKS      = 6,
    parameter int ROMSEL_DELAY_CLKS = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_rw,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        m2,
    output logic        romsel,
    output logic        cpu_rw,
    output logic [14:0] cpu_addr,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_oe,
    input  logic [7:0]  cpu_data_in,
    input  logic        irq,
    output logic        irq_sync,
    output logic [15:0] cycle_count
);
    localparam int CW = $clog2(M2_LOW_CLKS > M2_HIGH_CLKS ? M2_LOW_CLKS : M2_HIGH_CLKS);
    localparam logic [CW-1:0] LOW_LAST  = CW'(M2_LOW_CLKS - 1);
    localparam logic [CW-1:0] HIGH_LAST = CW'(M2_HIGH_CLKS - 1);
    localparam logic [CW-1:0] RS_DLY    = CW'(ROMSEL_DELAY_CLKS);

    if (M2_LOW_CLKS < 2 || M2_HIGH_CLKS < 2 || ROMSEL_DELAY_CLKS < 0 ||
        ROMSEL_DELAY_CLKS >= M2_HIGH_CLKS) begin : g_bad_params
        $error("famicom_cpu_bus_master: invalid M2 timing parameters");
    end

    typedef enum logic {ST_LOW, ST_HIGH} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            w_accept;
    logic            w_fall;
    logic            w_rsp;
    logic            w_high_next;
    logic            w_romsel_next;
    logic            r_active;
    logic            r_a15;
    logic            r_romsel;
    logic            r_cpu_rw;
    logic [14:0]     r_cpu_addr;
    logic [7:0]      r_cpu_data_out;
    logic            r_cpu_data_oe;
    logic            r_rsp_valid;
    logic [7:0]      r_rsp_rdata;
    logic [15:0]     r_cycle_count;
    logic            r_irq_meta;
    logic            r_irq_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = (r_state == ST_LOW) ? ((r_cnt == LOW_LAST)  ? ST_HIGH : ST_LOW)
                                           : ((r_cnt == HIGH_LAST) ? ST_LOW  : ST_HIGH);
        w_cnt_next   = (w_state_next != r_state) ? '0 : r_cnt + 1'b1;
    end

    // Pin values are computed from the next state so every pin comes straight off a flop.
    always_comb begin
        req_ready     = (r_state == ST_LOW) && (r_cnt == '0);
        w_accept      = req_valid && req_ready;
        w_fall        = (r_state == ST_HIGH) && (r_cnt == HIGH_LAST);
        w_rsp         = w_fall && r_active;
        w_high_next   = (w_state_next == ST_HIGH);
        w_romsel_next = !(w_high_next && (w_cnt_next >= RS_DLY) && r_a15);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active       <= 1'b0;
            r_a15          <= 1'b0;
            r_romsel       <= 1'b1;
            r_cpu_rw       <= 1'b1;
            r_cpu_addr     <= '0;
            r_cpu_data_out <= '0;
            r_cpu_data_oe  <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= '0;
            r_cycle_count  <= '0;
        end else begin
            r_romsel      <= w_romsel_next;
            r_cpu_data_oe <= w_high_next && !r_cpu_rw;
            r_rsp_valid   <= w_rsp;
            r_cycle_count <= r_cycle_count + {15'd0, w_fall};
            if (w_rsp && r_cpu_rw) r_rsp_rdata <= cpu_data_in;
            if (req_ready) begin
                r_active <= w_accept;
                r_a15    <= w_accept && req_addr[15];
                r_cpu_rw <= !w_accept || req_rw;
                if (w_accept) r_cpu_addr <= req_addr[14:0];
                if (w_accept && !req_rw) r_cpu_data_out <= req_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_meta <= 1'b1;
            r_irq_sync <= 1'b1;
        end else begin
            r_irq_meta <= irq;
            r_irq_sync <= r_irq_meta;
        end
    end

    assign m2           = (r_state == ST_HIGH);
    assign romsel       = r_romsel;
    assign cpu_rw       = r_cpu_rw;
    assign cpu_addr     = r_cpu_addr;
    assign cpu_data_out = r_cpu_data_out;
    assign cpu_data_oe  = r_cpu_data_oe;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign irq_sync     = r_irq_sync;
    assign cycle_count  = r_cycle_count;
endmodule

// File: tb/tb_famicom_cpu_bus_master.sv
// tb_famicom_cpu_bus_master: scenario tasks for the Famicom CPU bus master.
// Response data is checked against a queue of expectations filled when requests are driven.
module tb_famicom_cpu_bus_master;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_rw = 1'b1;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic [7:0]  cpu_data_in = '0;
    logic        irq = 1'b1;
    logic        req_ready, rsp_valid, m2, romsel, cpu_rw, cpu_data_oe, irq_sync;
    logic [7:0]  rsp_rdata, cpu_data_out;
    logic [14:0] cpu_addr;
    logic [15:0] cycle_count;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_d;

    famicom_cpu_bus_master dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .m2(m2), .romsel(romsel),
        .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
        .cpu_data_oe(cpu_data_oe), .cpu_data_in(cpu_data_in), .irq(irq),
        .irq_sync(irq_sync), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Scoreboard: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid=1 rdata=%h, required no response", rsp_rdata);
            end else begin
                exp_d = exp_q.pop_front();
                if (rsp_rdata !== exp_d) begin
                    errors++;
                    $display("FAIL rsp_rdata: got %h required %h", rsp_rdata, exp_d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_ready;
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: req_ready=%b after %0d clks, required 1", req_ready, n);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (m2 !== 1'b0) begin errors++; $display("FAIL rst_m2: got %b required 0", m2); end
        checks++; if (romsel !== 1'b1) begin errors++; $display("FAIL rst_romsel: got %b required 1", romsel); end
        checks++; if (cpu_rw !== 1'b1) begin errors++; $display("FAIL rst_cpu_rw: got %b required 1", cpu_rw); end
        checks++; if (cpu_addr !== 15'h0) begin errors++; $display("FAIL rst_cpu_addr: got %h required 0", cpu_addr); end
        checks++; if (cpu_data_out !== 8'h0 || cpu_data_oe !== 1'b0) begin errors++; $display("FAIL rst_data: out=%h oe=%b required 00/0", cpu_data_out, cpu_data_oe); end
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h0) begin errors++; $display("FAIL rst_rsp: valid=%b rdata=%h required 0/00", rsp_valid, rsp_rdata); end
        checks++; if (irq_sync !== 1'b1) begin errors++; $display("FAIL rst_irq_sync: got %b required 1", irq_sync); end
        checks++; if (cycle_count !== 16'h0) begin errors++; $display("FAIL rst_cycle_count: got %h required 0", cycle_count); end
        reset_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_idle;
        int romsel_low, rw_low;
        romsel_low = 0;
        rw_low = 0;
        for (int i = 0; i < 120; i++) begin
            checks++;
            if (m2 !== ((i % 12) >= 6)) begin
                errors++;
                $display("FAIL idle_m2 clk %0d: got %b required %b", i, m2, ((i % 12) >= 6));
            end
            if (romsel !== 1'b1) romsel_low++;
            if (cpu_rw !== 1'b1) rw_low++;
            @(negedge clk);
        end
        checks++; if (romsel_low != 0) begin errors++; $display("FAIL idle_romsel: low on %0d clks, required 0", romsel_low); end
        checks++; if (rw_low != 0) begin errors++; $display("FAIL idle_cpu_rw: low on %0d clks, required 0", rw_low); end
        checks++; if (cycle_count !== 16'd10) begin errors++; $display("FAIL idle_cycle_count: got %0d required 10", cycle_count); end
    endtask

    task automatic test_read;
        wait_ready();
        req_addr = 16'h8123; req_rw = 1'b1; req_valid = 1'b1; cpu_data_in = 8'hA5;
        exp_q.push_back(8'hA5);
        for (int k = 0; k <= 12; k++) begin
            if (k == 1) req_valid = 1'b0;
            if (k >= 1) begin
                checks++; if (cpu_addr !== 15'h0123 || cpu_rw !== 1'b1) begin errors++; $display("FAIL rd_addr T+%0d: addr=%h rw=%b required 0123/1", k, cpu_addr, cpu_rw); end
                checks++; if (m2 !== (k >= 6 && k <= 11)) begin errors++; $display("FAIL rd_m2 T+%0d: got %b required %b", k, m2, (k >= 6 && k <= 11)); end
                checks++; if (romsel !== !(k >= 7 && k <= 11)) begin errors++; $display("FAIL rd_romsel T+%0d: got %b required %b", k, romsel, !(k >= 7 && k <= 11)); end
                checks++; if (rsp_valid !== (k == 12)) begin errors++; $display("FAIL rd_rsp_valid T+%0d: got %b required %b", k, rsp_valid, (k == 12)); end
            end
            if (k == 12) begin
                checks++; if (rsp_rdata !== 8'hA5) begin errors++; $display("FAIL rd_rdata: got %h required a5", rsp_rdata); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_write;
        wait_ready();
        req_addr = 16'h6000; req_rw = 1'b0; req_wdata = 8'h3C; req_valid = 1'b1;
        exp_q.push_back(8'hA5);
        for (int k = 0; k <= 12; k++) begin
            if (k == 1) req_valid = 1'b0;
            if (k >= 1) begin
                checks++; if (romsel !== 1'b1) begin errors++; $display("FAIL wr_romsel T+%0d: got %b required 1", k, romsel); end
                checks++; if (cpu_rw !== 1'b0 || cpu_addr !== 15'h6000) begin errors++; $display("FAIL wr_rw T+%0d: rw=%b addr=%h required 0/6000", k, cpu_rw, cpu_addr); end
                checks++; if (cpu_data_oe !== (k >= 6 && k <= 11)) begin errors++; $display("FAIL wr_oe T+%0d: got %b required %b", k, cpu_data_oe, (k >= 6 && k <= 11)); end
                if (k >= 6 && k <= 11) begin
                    checks++; if (cpu_data_out !== 8'h3C) begin errors++; $display("FAIL wr_data T+%0d: got %h required 3c", k, cpu_data_out); end
                end
                checks++; if (rsp_valid !== (k == 12)) begin errors++; $display("FAIL wr_rsp_valid T+%0d: got %b required %b", k, rsp_valid, (k == 12)); end
            end
            @(negedge clk);
        end
        req_rw = 1'b1;
    endtask

    task automatic test_back_to_back;
        wait_ready();
        req_addr = 16'h8000; req_rw = 1'b1; req_valid = 1'b1; cpu_data_in = 8'h11;
        exp_q.push_back(8'h11);
        for (int k = 0; k <= 24; k++) begin
            if (k == 1) req_addr = 16'h8001;
            if (k == 12) begin
                cpu_data_in = 8'h22;
                exp_q.push_back(8'h22);
            end
            if (k == 13) req_valid = 1'b0;
            if (k == 6 || k == 12) begin
                checks++; if (req_ready !== (k == 12)) begin errors++; $display("FAIL b2b_ready T+%0d: got %b required %b", k, req_ready, (k == 12)); end
            end
            if (k >= 1) begin
                checks++; if (cpu_addr !== ((k <= 12) ? 15'h0000 : 15'h0001)) begin errors++; $display("FAIL b2b_addr T+%0d: got %h required %h", k, cpu_addr, ((k <= 12) ? 15'h0000 : 15'h0001)); end
                checks++; if (rsp_valid !== (k == 12 || k == 24)) begin errors++; $display("FAIL b2b_rsp_valid T+%0d: got %b required %b", k, rsp_valid, (k == 12 || k == 24)); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        wait_ready();
        req_addr = 16'hE000; req_rw = 1'b0; req_wdata = 8'h55; req_valid = 1'b1;
        exp_q.push_back(8'h22);
        for (int k = 0; k < 8; k++) begin
            if (k == 1) req_valid = 1'b0;
            @(negedge clk);
        end
        checks++; if (m2 !== 1'b1 || cpu_data_oe !== 1'b1 || romsel !== 1'b0) begin errors++; $display("FAIL mid_pre T+8: m2=%b oe=%b romsel=%b required 1/1/0", m2, cpu_data_oe, romsel); end
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        checks++; if (m2 !== 1'b0) begin errors++; $display("FAIL mid_m2: got %b required 0", m2); end
        checks++; if (cpu_data_oe !== 1'b0) begin errors++; $display("FAIL mid_oe: got %b required 0", cpu_data_oe); end
        checks++; if (romsel !== 1'b1) begin errors++; $display("FAIL mid_romsel: got %b required 1", romsel); end
        checks++; if (cpu_rw !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin errors++; $display("FAIL mid_misc: rw=%b rsp_valid=%b rdata=%h required 1/0/00", cpu_rw, rsp_valid, rsp_rdata); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        req_rw = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b required 1", req_ready); end
        repeat (14) @(negedge clk);
    endtask

    task automatic test_irq;
        #3 irq = 1'b0;
        @(negedge clk);
        checks++; if (irq_sync !== 1'b1) begin errors++; $display("FAIL irq_fall_1clk: got %b required 1", irq_sync); end
        @(negedge clk);
        checks++; if (irq_sync !== 1'b0) begin errors++; $display("FAIL irq_fall_2clk: got %b required 0", irq_sync); end
        #3 irq = 1'b1;
        @(negedge clk);
        checks++; if (irq_sync !== 1'b0) begin errors++; $display("FAIL irq_rise_1clk: got %b required 0", irq_sync); end
        @(negedge clk);
        checks++; if (irq_sync !== 1'b1) begin errors++; $display("FAIL irq_rise_2clk: got %b required 1", irq_sync); end
    endtask

    task automatic test_wrap;
        wait_ready();
        @(negedge clk);
        force dut.r_cycle_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_cycle_count;
        checks++; if (cycle_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h required ffff", cycle_count); end
        wait_ready();
        checks++; if (cycle_count !== 16'h0000) begin errors++; $display("FAIL wrap: got %h required 0000", cycle_count); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_mid();
        test_irq();
        test_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
